mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum number of bus-wait cycles before a bus-error exception is raised.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 cpurst_n  input  1  reset; synchronous, active-low.
REQ-004 Pipeline inputs, all registered EX/MEM outputs:
- ex2mem_wr_reg_ffout 1; ex2mem_wr_regindex_ffout 5; ex2mem_wr_wdata_ffout 32;
- ex2mem_memaddr_ffout 32; ex2mem_wr_memwdata_ffout 32; ex2mem_mem_op_ffout 3 (funct3);
- ex2mem_load_ffout 1; ex2mem_store_ffout 1; ex2mem_pc_ffout 32.
REQ-005 Data-bus outputs: dmem_req 1; dmem_we 1; dmem_addr 32 (word-aligned, bits [1:0]=0); dmem_wdata 32; dmem_be 4.
REQ-006 Data-bus inputs: dmem_gnt 1 (request accepted); dmem_rvalid 1 (read data valid); dmem_rdata 32.
REQ-007 mem_stall  output  1  high while a memory operation occupies MEM; the EX/MEM register holds while it is high.
REQ-008 Write-back outputs, all registered: mem2wb_wr_reg_ffout 1; mem2wb_wr_regindex_ffout 5; mem2wb_wr_wdata_ffout 32; mem2wb_exp_ffout 1; mem2wb_pc_ffout 32.

Function
REQ-009 FSM states: IDLE, REQ (waiting for dmem_gnt), WAIT_R (load granted, waiting for dmem_rvalid).
REQ-010 In IDLE with ex2mem_load_ffout or ex2mem_store_ffout high and the access aligned, the block drives dmem_req=1 combinationally in the same cycle.
REQ-011 dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be stay stable from issue until dmem_gnt is sampled high.
REQ-012 State transitions:
- REQ -> IDLE on gnt for a store.
- REQ -> IDLE on gnt plus rvalid in the same cycle for a load (zero-wait path).
- REQ -> WAIT_R on gnt without rvalid for a load.
- WAIT_R -> IDLE on rvalid.
REQ-013 mem_stall is combinational: it equals (load or store) AND NOT completion-this-cycle. A zero-wait access completing in its issue cycle therefore causes no stall.
REQ-014 Store byte enables and data, where a = addr[1:0]:
- sb: be = 0001 << a; wdata = byte replicated x4.
- sh: be = 0011 << a; wdata = halfword replicated x2.
- sw: be = 1111.
REQ-015 Load extraction uses addr[1:0]: lb/lh sign-extend; lbu/lhu zero-extend; lw passes dmem_rdata unchanged.
REQ-016 Misalignment: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0. No bus request is made. Next cycle mem2wb_exp_ffout=1 and mem2wb_wr_reg_ffout=0.
REQ-017 A mem_op_ffout outside {000,001,010,100,101} on a load, or outside {000,001,010} on a store, is treated identically to a misaligned access.
REQ-018 An 8-bit wait counter is cleared in IDLE and increments each cycle in REQ/WAIT_R. When it reaches TIMEOUT_CYCLES: return to IDLE, drop dmem_req, deassert mem_stall, register mem2wb_exp_ffout=1.
REQ-019 dmem_rvalid arriving in IDLE (e.g. late after a timeout) is ignored.
REQ-020 Write-back register updates every cycle mem_stall=0:
- wr_wdata = load result for loads, otherwise ex2mem_wr_wdata_ffout.
- wr_reg = ex2mem_wr_reg_ffout AND NOT exception; stores force wr_reg=0.
- pc = ex2mem_pc_ffout.
REQ-021 While mem_stall=1, mem2wb_wr_reg_ffout and mem2wb_exp_ffout register 0 (bubble); the other write-back outputs hold.
REQ-022 mem2wb_exp_ffout is a one-cycle pulse per faulting access.

Reset
REQ-023 With cpurst_n=0 at a clock edge, FSM=IDLE, counter=0, and every registered output becomes 0.
REQ-024 During reset, dmem_req=0 and mem_stall=0 regardless of inputs, including reset asserted mid-access; an outstanding bus transaction is abandoned.

Structure
REQ-025 A shared package holds the funct3 load/store encodings, the FSM state typedef, and the TIMEOUT_CYCLES default.
REQ-026 One sub-module, mem_align: combinational store byte-enable/data generation, load extraction, and the misalign check.

Verification
REQ-027 sw addr 0x100, wdata 0xDEADBEEF, gnt in issue cycle -> be=1111, addr=0x100, mem_stall=0 throughout, mem2wb_wr_reg_ffout=0 next cycle.
REQ-028 lb addr 0x203, rdata 0x80FF_FF7F, gnt cycle 1, rvalid cycle 3 -> mem_stall high cycles 0-2; next cycle mem2wb_wr_wdata_ffout=0xFFFFFF80 (byte 0x80 sign-extended).
REQ-029 lhu addr 0x102, rdata 0x8001_0000 with gnt+rvalid same cycle -> no stall; mem2wb_wr_wdata_ffout=0x00008001.
REQ-030 lw addr 0x101 -> dmem_req stays 0, mem2wb_exp_ffout=1 for exactly one cycle, mem2wb_wr_reg_ffout=0.
REQ-031 Load with gnt never asserted, TIMEOUT_CYCLES=4 -> mem_stall high 4 cycles, then exp pulse; a later rvalid is ignored.
REQ-032 cpurst_n=0 during WAIT_R -> next cycle IDLE, dmem_req=0, all mem2wb outputs 0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: funct3 encodings, FSM state type and timeout default shared by the MEM stage.
package mem_access_pkg;
   localparam int TIMEOUT_DEFAULT = 255;
   localparam logic [2:0] LD_B  = 3'b000;
   localparam logic [2:0] LD_H  = 3'b001;
   localparam logic [2:0] LD_W  = 3'b010;
   localparam logic [2:0] LD_BU = 3'b100;
   localparam logic [2:0] LD_HU = 3'b101;
   localparam logic [2:0] ST_B  = 3'b000;
   localparam logic [2:0] ST_H  = 3'b001;
   localparam logic [2:0] ST_W  = 3'b010;
   typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_e;
endpackage

// File: rtl/mem_align.sv
// mem_align: store byte-enable/data lane steering, load extraction and misalign/illegal-op detection.
module mem_align
   import mem_access_pkg::*;
(
   input  logic        load_i,
   input  logic        store_i,
   input  logic [2:0]  op_i,
   input  logic [1:0]  addr_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] ld_data_o,
   output logic        misalign_o
);
   logic [15:0] sh_data;
   logic        bad_op;
   logic        half;
   logic        word;
   always_comb begin
      sh_data    = 16'(rdata_i >> {addr_i, 3'b000});
      half       = op_i[1:0] == 2'b01;
      word       = op_i == LD_W;
      // illegal funct3 values fault exactly like a misaligned access
      bad_op     = load_i ? !(op_i inside {LD_B, LD_H, LD_W, LD_BU, LD_HU})
                          : !(op_i inside {ST_B, ST_H, ST_W});
      misalign_o = (load_i || store_i) && (bad_op || (half && addr_i[0]) || (word && addr_i != 2'b00));
      be_o       = op_i == ST_B ? 4'b0001 << addr_i : op_i == ST_H ? 4'b0011 << addr_i : 4'b1111;
      wdata_o    = op_i == ST_B ? {4{wdata_i[7:0]}} : op_i == ST_H ? {2{wdata_i[15:0]}} : wdata_i;
      ld_data_o  = op_i == LD_B  ? {{24{sh_data[7]}}, sh_data[7:0]} :
                   op_i == LD_H  ? {{16{sh_data[15]}}, sh_data} :
                   op_i == LD_BU ? {24'd0, sh_data[7:0]} :
                   op_i == LD_HU ? {16'd0, sh_data} : rdata_i;
   end
endmodule

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage driving a req/gnt/rvalid data bus with stall, timeout and
// misalign exceptions, and registering the MEM/WB outputs.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        cpurst_n,
   input  logic        ex2mem_wr_reg_ffout,
   input  logic [4:0]  ex2mem_wr_regindex_ffout,
   input  logic [31:0] ex2mem_wr_wdata_ffout,
   input  logic [31:0] ex2mem_memaddr_ffout,
   input  logic [31:0] ex2mem_wr_memwdata_ffout,
   input  logic [2:0]  ex2mem_mem_op_ffout,
   input  logic        ex2mem_load_ffout,
   input  logic        ex2mem_store_ffout,
   input  logic [31:0] ex2mem_pc_ffout,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        mem_stall,
   output logic        mem2wb_wr_reg_ffout,
   output logic [4:0]  mem2wb_wr_regindex_ffout,
   output logic [31:0] mem2wb_wr_wdata_ffout,
   output logic        mem2wb_exp_ffout,
   output logic [31:0] mem2wb_pc_ffout
);
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        acc, misalign, req, cmpl, tmo, exc, stall;
   logic [31:0] ld_data;
   logic        wr_reg_q, exp_q;
   logic [4:0]  regidx_q;
   logic [31:0] wdata_q, pc_q;
   assign acc = ex2mem_load_ffout || ex2mem_store_ffout;
   mem_align u_align (
      .load_i     (ex2mem_load_ffout),
      .store_i    (ex2mem_store_ffout),
      .op_i       (ex2mem_mem_op_ffout),
      .addr_i     (ex2mem_memaddr_ffout[1:0]),
      .wdata_i    (ex2mem_wr_memwdata_ffout),
      .rdata_i    (dmem_rdata),
      .be_o       (dmem_be),
      .wdata_o    (dmem_wdata),
      .ld_data_o  (ld_data),
      .misalign_o (misalign)
   );
   always_comb begin
      state_d = IDLE;
      cnt_d   = 8'd0;
      req     = 1'b0;
      cmpl    = 1'b0;
      tmo     = 1'b0;
      exc     = 1'b0;
      stall   = 1'b0;
      if (cpurst_n && acc) begin
         case (state_q)
            IDLE: begin
               exc     = misalign;
               req     = !misalign;
               cmpl    = req && dmem_gnt && (ex2mem_store_ffout || dmem_rvalid);
               state_d = (!req || cmpl) ? IDLE : (dmem_gnt ? WAIT_R : REQ);
            end
            REQ: begin
               tmo     = cnt_q == TMO_LAST;
               exc     = tmo;
               req     = !tmo;
               cmpl    = req && dmem_gnt && (ex2mem_store_ffout || dmem_rvalid);
               state_d = (tmo || cmpl) ? IDLE : (dmem_gnt ? WAIT_R : REQ);
               cnt_d   = cnt_q + 8'd1;
            end
            WAIT_R: begin
               tmo     = cnt_q == TMO_LAST;
               exc     = tmo;
               cmpl    = !tmo && dmem_rvalid;
               state_d = (tmo || cmpl) ? IDLE : WAIT_R;
               cnt_d   = cnt_q + 8'd1;
            end
            default: state_d = IDLE;
         endcase
         stall = !(cmpl || exc);
      end
   end
   always_ff @(posedge clk) begin
      if (!cpurst_n) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   // a stalled cycle inserts a bubble: only the valid/exception bits are cleared
   always_ff @(posedge clk) begin
      if (!cpurst_n) begin
         wr_reg_q <= 1'b0;
         exp_q    <= 1'b0;
         regidx_q <= 5'd0;
         wdata_q  <= 32'd0;
         pc_q     <= 32'd0;
      end else if (stall) begin
         wr_reg_q <= 1'b0;
         exp_q    <= 1'b0;
      end else begin
         wr_reg_q <= ex2mem_wr_reg_ffout && !exc && !ex2mem_store_ffout;
         exp_q    <= exc;
         regidx_q <= ex2mem_wr_regindex_ffout;
         wdata_q  <= ex2mem_load_ffout ? ld_data : ex2mem_wr_wdata_ffout;
         pc_q     <= ex2mem_pc_ffout;
      end
   end
   assign dmem_req                 = req;
   assign dmem_we                  = ex2mem_store_ffout;
   assign dmem_addr                = {ex2mem_memaddr_ffout[31:2], 2'b00};
   assign mem_stall                = stall;
   assign mem2wb_wr_reg_ffout      = wr_reg_q;
   assign mem2wb_wr_regindex_ffout = regidx_q;
   assign mem2wb_wr_wdata_ffout    = wdata_q;
   assign mem2wb_exp_ffout         = exp_q;
   assign mem2wb_pc_ffout          = pc_q;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: table vectors, hand sequences for wait/timeout/reset corners, and random
// transactions checked against an arithmetic reference model of the MEM stage.
module tb_mem_access;
   localparam int T = 4;
   logic        clk = 1'b0;
   logic        cpurst_n;
   logic        wr, ld, st;
   logic [4:0]  idx;
   logic [31:0] xw, addr, mwd, pc;
   logic [2:0]  op;
   logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid, mem_stall;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        wb_wr, wb_exp;
   logic [4:0]  wb_idx;
   logic [31:0] wb_wd, wb_pc;
   int          n_chk = 0;
   int          n_fail = 0;
   always #5 clk = ~clk;
   mem_access #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .cpurst_n(cpurst_n),
      .ex2mem_wr_reg_ffout(wr), .ex2mem_wr_regindex_ffout(idx), .ex2mem_wr_wdata_ffout(xw),
      .ex2mem_memaddr_ffout(addr), .ex2mem_wr_memwdata_ffout(mwd), .ex2mem_mem_op_ffout(op),
      .ex2mem_load_ffout(ld), .ex2mem_store_ffout(st), .ex2mem_pc_ffout(pc),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_be(dmem_be), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .mem_stall(mem_stall),
      .mem2wb_wr_reg_ffout(wb_wr), .mem2wb_wr_regindex_ffout(wb_idx), .mem2wb_wr_wdata_ffout(wb_wd),
      .mem2wb_exp_ffout(wb_exp), .mem2wb_pc_ffout(wb_pc)
   );
   typedef struct {
      logic ld, st; logic [2:0] op; logic [31:0] addr, mwd, xw; logic wr;
      logic [31:0] rdata; logic gnt, rv;
      logic req; logic [3:0] be; logic [31:0] dwd; logic wwr; logic [31:0] wwd; logic wexp;
   } vec_t;
   vec_t tbl[14];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic set_ex(input logic l, input logic s, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] m, input logic [31:0] x, input logic w,
                         input logic [4:0] i, input logic [31:0] p);
      ld = l; st = s; op = o; addr = a; mwd = m; xw = x; wr = w; idx = i; pc = p;
   endtask
   task automatic set_bus(input logic g, input logic r, input logic [31:0] d);
      dmem_gnt = g; dmem_rvalid = r; dmem_rdata = d;
   endtask
   function automatic logic [31:0] ld_model(input logic [2:0] o, input logic [1:0] a, input logic [31:0] d);
      logic [31:0] s;
      s = d >> (8 * a);
      case (o)
         3'd0: return 32'($signed(s[7:0]));
         3'd1: return 32'($signed(s[15:0]));
         3'd4: return 32'(s[7:0]);
         3'd5: return 32'(s[15:0]);
         default: return d;
      endcase
   endfunction
   function automatic logic [3:0] be_model(input logic [2:0] o, input logic [1:0] a);
      return o == 3'd0 ? 4'(1 << a) : o == 3'd1 ? 4'(3 << a) : 4'hF;
   endfunction
   function automatic logic [31:0] wd_model(input logic [2:0] o, input logic [31:0] d);
      return o == 3'd0 ? d[7:0] * 32'h01010101 : o == 3'd1 ? d[15:0] * 32'h00010001 : d;
   endfunction
   function automatic logic fault_model(input logic l, input logic [2:0] o, input logic [31:0] a);
      logic legal;
      legal = l ? (o inside {0, 1, 2, 4, 5}) : (o inside {0, 1, 2});
      return !legal || (a % (32'd1 << o[1:0])) != 0;
   endfunction
   task automatic run_table();
      for (int i = 0; i <= 14; i++) begin
         cyc();
         if (i > 0) begin
            chk($sformatf("tbl%0d_wb_wr", i - 1), wb_wr, tbl[i - 1].wwr);
            chk($sformatf("tbl%0d_wb_wd", i - 1), wb_wd, tbl[i - 1].wwd);
            chk($sformatf("tbl%0d_wb_exp", i - 1), wb_exp, tbl[i - 1].wexp);
            chk($sformatf("tbl%0d_wb_pc", i - 1), wb_pc, 32'h1000 + 4 * (i - 1));
            chk($sformatf("tbl%0d_wb_idx", i - 1), wb_idx, 5'(i - 1));
         end
         if (i < 14) begin
            set_ex(tbl[i].ld, tbl[i].st, tbl[i].op, tbl[i].addr, tbl[i].mwd, tbl[i].xw, tbl[i].wr,
                   5'(i), 32'h1000 + 4 * i);
            set_bus(tbl[i].gnt, tbl[i].rv, tbl[i].rdata);
            #2;
            chk($sformatf("tbl%0d_req", i), dmem_req, tbl[i].req);
            chk($sformatf("tbl%0d_stall", i), mem_stall, 0);
            chk($sformatf("tbl%0d_we", i), dmem_we, tbl[i].st);
            if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), dmem_addr, tbl[i].addr & ~32'h3);
            if (tbl[i].req && tbl[i].st) begin
               chk($sformatf("tbl%0d_be", i), dmem_be, tbl[i].be);
               chk($sformatf("tbl%0d_dwd", i), dmem_wdata, tbl[i].dwd);
            end
         end else begin
            set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
            set_bus(0, 0, 0);
         end
      end
   endtask
   task automatic run_random(input int n);
      for (int t = 0; t < n; t++) begin
         int kind, g, r, c, last;
         logic l, s, a, f, e, w;
         logic [2:0] o;
         logic [31:0] ad, m, x, p, rd;
         logic [4:0] ix;
         kind = $urandom_range(0, 9);
         l = kind >= 1 && kind <= 5;
         s = kind >= 6;
         a = l || s;
         o = $urandom_range(0, 9) < 8 ? (l ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 2)))
                                      : 3'($urandom_range(0, 7));
         if (l && o == 3'd3) o = 3'd4;
         ad = $urandom; m = $urandom; x = $urandom; p = $urandom; rd = $urandom;
         ix = 5'($urandom); w = 1'($urandom);
         if ($urandom_range(0, 3) != 0) ad[1:0] = $urandom_range(0, 1) ? 2'b00 : ad[1:0] & {1'b1, ~o[0]};
         g = $urandom_range(0, 5);
         r = g + $urandom_range(0, 2);
         f = a && fault_model(l, o, ad);
         c = s ? g : r;
         last = (!a || f) ? 0 : (c < T ? c : T);
         e = f || (a && !f && c >= T);
         for (int k = 0; k <= last; k++) begin
            cyc();
            if (k == 0) set_ex(l, s, o, ad, m, x, w, ix, p);
            set_bus(a && k == g, l ? k == r : !a && 1'($urandom), k == r ? rd : $urandom);
            #2;
            chk("rnd_req", dmem_req, a && !f && k <= g && k < T);
            chk("rnd_stall", mem_stall, a && !f && k < last);
            if (k == 0 && a && !f) begin
               chk("rnd_addr", dmem_addr, {ad[31:2], 2'b00});
               chk("rnd_we", dmem_we, s);
               if (s) begin
                  chk("rnd_be", dmem_be, be_model(o, ad[1:0]));
                  chk("rnd_dwd", dmem_wdata, wd_model(o, m));
               end
            end
         end
         cyc();
         set_ex(0, 0, 0, $urandom, $urandom, $urandom, 0, 0, $urandom);
         set_bus(0, 1'($urandom), $urandom);
         #2;
         chk("rnd_wb_exp", wb_exp, e);
         chk("rnd_wb_wr", wb_wr, w && !e && !s);
         chk("rnd_wb_pc", wb_pc, p);
         chk("rnd_wb_idx", wb_idx, ix);
         if (!e) chk("rnd_wb_wd", wb_wd, l ? ld_model(o, ad[1:0], rd) : x);
      end
   endtask
   initial begin
      tbl[0]  = '{0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h55, 1, 32'h0, 1, 0, 1, 4'hF, 32'hDEADBEEF, 0, 32'h55, 0};
      tbl[1]  = '{0, 1, 3'b000, 32'h103, 32'h000000A5, 32'h66, 1, 32'h0, 1, 0, 1, 4'h8, 32'hA5A5A5A5, 0, 32'h66, 0};
      tbl[2]  = '{0, 1, 3'b001, 32'h202, 32'h1234BEEF, 32'h77, 1, 32'h0, 1, 0, 1, 4'hC, 32'hBEEFBEEF, 0, 32'h77, 0};
      tbl[3]  = '{1, 0, 3'b101, 32'h102, 32'h0, 32'h0, 1, 32'h80010000, 1, 1, 1, 4'h0, 32'h0, 1, 32'h00008001, 0};
      tbl[4]  = '{1, 0, 3'b000, 32'h201, 32'h0, 32'h0, 1, 32'h00008000, 1, 1, 1, 4'h0, 32'h0, 1, 32'hFFFFFF80, 0};
      tbl[5]  = '{1, 0, 3'b100, 32'h203, 32'h0, 32'h0, 1, 32'hC3000000, 1, 1, 1, 4'h0, 32'h0, 1, 32'h000000C3, 0};
      tbl[6]  = '{1, 0, 3'b001, 32'h100, 32'h0, 32'h0, 1, 32'h0000F00D, 1, 1, 1, 4'h0, 32'h0, 1, 32'hFFFFF00D, 0};
      tbl[7]  = '{1, 0, 3'b010, 32'h104, 32'h0, 32'h0, 1, 32'hCAFEF00D, 1, 1, 1, 4'h0, 32'h0, 1, 32'hCAFEF00D, 0};
      tbl[8]  = '{1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 1, 32'h0, 0, 0, 0, 4'h0, 32'h0, 0, 32'h0, 1};
      tbl[9]  = '{0, 1, 3'b001, 32'h103, 32'h0, 32'h99, 1, 32'h0, 0, 0, 0, 4'h0, 32'h0, 0, 32'h99, 1};
      tbl[10] = '{1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 32'h0, 1, 1, 0, 4'h0, 32'h0, 0, 32'h0, 1};
      tbl[11] = '{0, 1, 3'b100, 32'h100, 32'h0, 32'hAA, 1, 32'h0, 1, 0, 0, 4'h0, 32'h0, 0, 32'hAA, 1};
      tbl[12] = '{0, 0, 3'b000, 32'h0, 32'h0, 32'h12345678, 1, 32'hFFFFFFFF, 1, 1, 0, 4'h0, 32'h0, 1, 32'h12345678, 0};
      tbl[13] = '{1, 0, 3'b010, 32'h108, 32'h0, 32'h0, 0, 32'h13572468, 1, 1, 1, 4'h0, 32'h0, 0, 32'h13572468, 0};
      cpurst_n = 1'b0;
      set_ex(1, 0, 3'b010, 32'h100, 32'h0, 32'hFFFF, 1, 5'd3, 32'h44);
      set_bus(0, 0, 0);
      cyc();
      cyc();
      #2;
      chk("rst_req", dmem_req, 0);
      chk("rst_stall", mem_stall, 0);
      chk("rst_wb_wr", wb_wr, 0);
      chk("rst_wb_idx", wb_idx, 0);
      chk("rst_wb_wd", wb_wd, 0);
      chk("rst_wb_exp", wb_exp, 0);
      chk("rst_wb_pc", wb_pc, 0);
      set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cpurst_n = 1'b1;
      run_table();
      // lb with grant one cycle late and read data two cycles after that
      cyc();
      set_ex(1, 0, 3'b000, 32'h203, 32'h0, 32'h0, 1, 5'd5, 32'h2000);
      set_bus(0, 0, 32'h11111111);
      #2;
      chk("lb_c0_stall", mem_stall, 1);
      chk("lb_c0_req", dmem_req, 1);
      cyc();
      set_bus(1, 0, 32'h22222222);
      #2;
      chk("lb_c1_stall", mem_stall, 1);
      chk("lb_c1_req", dmem_req, 1);
      chk("lb_bubble_wr", wb_wr, 0);
      chk("lb_bubble_exp", wb_exp, 0);
      cyc();
      set_bus(0, 0, 32'h33333333);
      #2;
      chk("lb_c2_stall", mem_stall, 1);
      chk("lb_c2_req", dmem_req, 0);
      cyc();
      set_bus(0, 1, 32'h80FFFF7F);
      #2;
      chk("lb_c3_stall", mem_stall, 0);
      cyc();
      set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
      set_bus(0, 0, 0);
      #2;
      chk("lb_wb_wd", wb_wd, 32'hFFFFFF80);
      chk("lb_wb_wr", wb_wr, 1);
      chk("lb_wb_pc", wb_pc, 32'h2000);
      // load that is never granted runs into the timeout
      for (int k = 0; k <= T; k++) begin
         cyc();
         if (k == 0) set_ex(1, 0, 3'b010, 32'h300, 32'h0, 32'h0, 1, 5'd7, 32'h3000);
         #2;
         chk($sformatf("tmo_c%0d_stall", k), mem_stall, k < T);
         chk($sformatf("tmo_c%0d_req", k), dmem_req, k < T);
      end
      cyc();
      set_ex(0, 0, 0, 0, 0, 32'h4444, 0, 5'd9, 32'h3333);
      set_bus(0, 1, 32'hABCDABCD);
      #2;
      chk("tmo_exp", wb_exp, 1);
      chk("tmo_wr", wb_wr, 0);
      chk("tmo_late_rv_stall", mem_stall, 0);
      chk("tmo_late_rv_req", dmem_req, 0);
      cyc();
      set_bus(0, 0, 0);
      #2;
      chk("tmo_exp_pulse", wb_exp, 0);
      chk("tmo_nop_wd", wb_wd, 32'h4444);
      // reset while the load waits for read data
      cyc();
      set_ex(1, 0, 3'b010, 32'h400, 32'h0, 32'h0, 1, 5'd11, 32'h4000);
      set_bus(1, 0, 0);
      #2;
      chk("rw_c0_stall", mem_stall, 1);
      cyc();
      set_bus(0, 0, 0);
      #2;
      chk("rw_c1_stall", mem_stall, 1);
      chk("rw_c1_req", dmem_req, 0);
      cpurst_n = 1'b0;
      #1;
      chk("rw_rst_stall", mem_stall, 0);
      chk("rw_rst_req", dmem_req, 0);
      cyc();
      #2;
      chk("rw_rst_wb_wr", wb_wr, 0);
      chk("rw_rst_wb_idx", wb_idx, 0);
      chk("rw_rst_wb_wd", wb_wd, 0);
      chk("rw_rst_wb_exp", wb_exp, 0);
      chk("rw_rst_wb_pc", wb_pc, 0);
      chk("rw_rst_req2", dmem_req, 0);
      set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cpurst_n = 1'b1;
      cyc();
      set_ex(1, 0, 3'b010, 32'h404, 32'h0, 32'h0, 1, 5'd12, 32'h4004);
      set_bus(1, 1, 32'h0BADF00D);
      #2;
      chk("rw_post_req", dmem_req, 1);
      chk("rw_post_stall", mem_stall, 0);
      cyc();
      set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
      set_bus(0, 0, 0);
      #2;
      chk("rw_post_wd", wb_wd, 32'h0BADF00D);
      run_random(300);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
